tff_toggle_sched: RTL and testbench
===================================

// Module: tff_toggle_sched
// PURPOSE
//  Multi-channel scheduler for a bank of enable-gated toggle flops.
//  - Each channel drives the enable of one T-FF from a programmable period and toggle count.
//  - Outputs are divided/gated square-wave strobes.
//  - Sits between the register/config layer and the toggle-flop bank.
//  - Sequences start/stop/done per channel; the config port is shared by all channels.
// PARAMETERS
//  NUM_CH  4  number of independent toggle channels (>=1)
//  CNT_W   8  width of period and toggle-count fields
// PORTS
//  Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
//  clk         in   1                      clock
//  rst_n       in   1                      async active-low reset
//  cfg_valid   in   1                      config write request
//  cfg_ready   out  1                      config write accepted when valid&ready
//  cfg_ch      in   $clog2(NUM_CH) (min 1) target channel of config write
//  cfg_period  in   CNT_W                  cycles between enable pulses (0 treated as 1)
//  cfg_count   in   CNT_W                  toggles to issue; 0 = free-run until stop
//  start       in   NUM_CH                 per-channel start strobe
//  stop        in   NUM_CH                 per-channel abort strobe
//  busy        out  NUM_CH                 channel in RUN
//  tgl_en      out  NUM_CH                 registered one-cycle enable to T-FF
//  done        out  NUM_CH                 one-cycle pulse, final counted toggle issued
//  q           out  NUM_CH                 T-FF state per channel
// BEHAVIOUR
//  Reset:
//  - All registers clear asynchronously: busy=0, tgl_en=0, done=0, q=0.
//  - Stored period=1, count=0; state CH_IDLE.
//  Config:
//  - cfg_ready = ~busy[cfg_ch] (combinational). cfg_ch >= NUM_CH -> cfg_ready=0, never accepted.
//  - Accepted write latches period/count into the channel; takes effect on next start.
//  FSM per channel (CH_IDLE, CH_RUN):
//  - IDLE->RUN on start&~stop. Counter loads P-1, remaining loads count; busy=1 from next cycle.
//  - RUN: counter decrements each cycle.
//  - Counter==0 at an edge: tgl_en=1 for the following cycle, counter reloads P-1.
//  - Resulting tgl_en cycles: edges P, 2P, ... after start.
//  - q toggles on the edge ending each tgl_en cycle; q holds otherwise.
//  - Counted mode: remaining decrements per pulse.
//  - On the final pulse, done=1 in the same cycle as that tgl_en.
//  - busy falls on the same edge q toggles; ->IDLE.
//  - Free-run (count=0): pulses until stop; done never asserts.
//  - RUN->IDLE on stop at next edge: no further tgl_en, no done, q holds current value.
//  - A tgl_en already registered still completes its toggle.
//  Collisions:
//  - start while busy: ignored.
//  - start&stop same cycle while idle: stop wins, stays idle.
//  - stop while idle: no effect.
//  - Channels are independent; any mix may pulse in the same cycle.
//  Arithmetic:
//  - Counters are CNT_W unsigned. P=0 behaves exactly as P=1 (tgl_en every cycle).
//  - Max period 2^CNT_W-1; no wrap within a period.
//  Reset mid-RUN: immediate return to reset values, including q=0.
// STRUCTURE
//  Package tff_sched_pkg: ch_state_e {CH_IDLE, CH_RUN}; CNT_W default constant;
//  ch_cfg_t struct {period, count}.
//  Sub-module tff_sched_chan: one channel (cfg regs, period/remaining counters, FSM, T-FF).
//  Top: cfg_ready mux, cfg_ch decode to per-channel write strobes, generate loop of NUM_CH channels.
// TESTING
//  1. Reset during RUN -> all outputs 0 immediately; next start behaves as fresh.
//  2. ch0 cfg P=3,count=2; start@edge0:
//     - tgl_en at edges 3,6; q 0->1->0.
//     - done with 2nd tgl_en; busy low after edge 7.
//  3. ch1 P=0,count=0; start -> tgl_en every cycle; q toggles every edge; stop -> tgl_en stops, q holds.
//  4. ch2 busy:
//     - cfg write to ch2 -> cfg_ready=0, config unchanged.
//     - Simultaneous write to idle ch3 -> accepted.
//  5. start+stop same cycle on idle ch0 -> busy stays 0.
//     start on busy ch0 mid-period -> pulse spacing unchanged.
//  6. All 4 channels P=1,count=4 started together -> simultaneous tgl_en ×4, four done pulses same cycle.

Source files
------------

// File: rtl/tff_sched_pkg.sv
// Shared types and helpers for the toggle-flop enable scheduler.
package tff_sched_pkg;

   localparam int unsigned CNT_W_DEF = 8;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] period;
      logic [CNT_W_DEF-1:0] count;
   } ch_cfg_t;

   // Period counter reload value; a programmed period of 0 behaves as 1.
   function automatic logic [CNT_W_DEF-1:0] reload_val(input logic [CNT_W_DEF-1:0] p);
      return (p == '0) ? '0 : p - CNT_W_DEF'(1);
   endfunction

endpackage

// File: rtl/tff_sched_chan.sv
// One scheduler channel: stored config, period and remaining counters, run FSM and the T-FF.
module tff_sched_chan
   import tff_sched_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             tgl_en,
   output logic             done,
   output logic             q
);

   ch_state_e        state_q;
   ch_cfg_t          cfg_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] per_q;
   logic             free_q;
   logic [CNT_W-1:0] start_reload;

   assign start_reload = CNT_W'(reload_val(cfg_q.period));

   // Reload value is captured at start so a config write in the start cycle cannot skew the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CH_IDLE;
         cfg_q   <= '{period: CNT_W_DEF'(1), count: '0};
         cnt_q   <= '0;
         rem_q   <= '0;
         per_q   <= '0;
         free_q  <= 1'b0;
         busy    <= 1'b0;
         tgl_en  <= 1'b0;
         done    <= 1'b0;
         q       <= 1'b0;
      end else begin
         q      <= q ^ tgl_en;
         tgl_en <= 1'b0;
         done   <= 1'b0;
         if (cfg_we) begin
            cfg_q <= '{period: CNT_W_DEF'(cfg_period), count: CNT_W_DEF'(cfg_count)};
         end
         case (state_q)
            CH_IDLE: begin
               if (start && !stop) begin
                  state_q <= CH_RUN;
                  busy    <= 1'b1;
                  cnt_q   <= start_reload;
                  per_q   <= start_reload;
                  rem_q   <= CNT_W'(cfg_q.count);
                  free_q  <= (cfg_q.count == '0);
               end
            end
            CH_RUN: begin
               if (stop || done) begin
                  state_q <= CH_IDLE;
                  busy    <= 1'b0;
               end else if (cnt_q == '0) begin
                  cnt_q  <= per_q;
                  tgl_en <= 1'b1;
                  if (!free_q) begin
                     rem_q <= rem_q - CNT_W'(1);
                     done  <= (rem_q == CNT_W'(1));
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= CH_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tff_toggle_sched.sv
// Multi-channel toggle-flop enable scheduler with a shared config write port.
module tff_toggle_sched
   import tff_sched_pkg::*;
#(
   parameter  int unsigned NUM_CH = 4,
   parameter  int unsigned CNT_W  = CNT_W_DEF,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic [NUM_CH-1:0] start,
   input  logic [NUM_CH-1:0] stop,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] tgl_en,
   output logic [NUM_CH-1:0] done,
   output logic [NUM_CH-1:0] q
);

   logic [NUM_CH-1:0] cfg_we;

   // A running channel refuses config; out-of-range channel numbers are never accepted.
   assign cfg_ready = (32'(cfg_ch) < NUM_CH) && !busy[cfg_ch];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign cfg_we[i] = cfg_valid && cfg_ready && (32'(cfg_ch) == i);

      tff_sched_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .cfg_we     (cfg_we[i]),
         .cfg_period (cfg_period),
         .cfg_count  (cfg_count),
         .start      (start[i]),
         .stop       (stop[i]),
         .busy       (busy[i]),
         .tgl_en     (tgl_en[i]),
         .done       (done[i]),
         .q          (q[i])
      );
   end

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Randomized and directed bench for tff_toggle_sched against an elapsed-time reference model.
module tb_tff_toggle_sched;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_period;
   logic [CNT_W-1:0]  cfg_count;
   logic [NUM_CH-1:0] start;
   logic [NUM_CH-1:0] stop;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] tgl_en;
   logic [NUM_CH-1:0] done;
   logic [NUM_CH-1:0] q;

   int n_chk;
   int n_bad;

   // Reference model: a run is described by its start edge, effective period and pulse count.
   logic [NUM_CH-1:0] m_busy, m_tgl, m_done, m_q;
   int m_t0 [NUM_CH];
   int m_pp [NUM_CH];
   int m_n  [NUM_CH];
   int cfg_p[NUM_CH];
   int cfg_n[NUM_CH];
   int ecnt;

   tff_toggle_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_count  (cfg_count),
      .start      (start),
      .stop       (stop),
      .busy       (busy),
      .tgl_en     (tgl_en),
      .done       (done),
      .q          (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = '0; m_tgl = '0; m_done = '0; m_q = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         cfg_p[c] = 1; cfg_n[c] = 0; m_t0[c] = 0; m_pp[c] = 1; m_n[c] = 0;
      end
   endtask

   task automatic model_update();
      logic [NUM_CH-1:0] old_busy;
      int k;
      old_busy = m_busy;
      for (int c = 0; c < NUM_CH; c++) begin
         m_q[c]    = m_q[c] ^ m_tgl[c];
         m_tgl[c]  = 1'b0;
         m_done[c] = 1'b0;
         if (m_busy[c]) begin
            k = ecnt - m_t0[c];
            if (stop[c] || (m_n[c] > 0 && k == m_n[c] * m_pp[c] + 1)) begin
               m_busy[c] = 1'b0;
            end else if (k % m_pp[c] == 0) begin
               m_tgl[c] = 1'b1;
               if (m_n[c] > 0 && k == m_n[c] * m_pp[c]) m_done[c] = 1'b1;
            end
         end else if (start[c] && !stop[c]) begin
            m_busy[c] = 1'b1;
            m_t0[c]   = ecnt;
            m_pp[c]   = (cfg_p[c] == 0) ? 1 : cfg_p[c];
            m_n[c]    = cfg_n[c];
         end
      end
      if (cfg_valid && !old_busy[cfg_ch]) begin
         cfg_p[cfg_ch] = int'(cfg_period);
         cfg_n[cfg_ch] = int'(cfg_count);
      end
      ecnt++;
   endtask

   // Called at a falling edge; inputs must already be set for the coming rising edge.
   task automatic tick();
      #1;
      check("cfg_ready", 32'(cfg_ready), 32'(!m_busy[cfg_ch]));
      @(posedge clk);
      model_update();
      @(negedge clk);
      check("busy",   32'(busy),   32'(m_busy));
      check("tgl_en", 32'(tgl_en), 32'(m_tgl));
      check("done",   32'(done),   32'(m_done));
      check("q",      32'(q),      32'(m_q));
   endtask

   task automatic idle_inputs();
      cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_count = '0;
      start = '0; stop = '0;
   endtask

   task automatic cfg_wr(input int ch, input int p, input int n);
      cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = CNT_W'(p); cfg_count = CNT_W'(n);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic stop_all();
      stop = '1; tick(); stop = '0; tick();
   endtask

   initial begin
      int pulses;
      n_chk = 0; n_bad = 0; ecnt = 0;
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_tgl",  32'(tgl_en), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_q",    32'(q), 32'(0));
      rst_n = 1'b1;
      tick();

      // ch0 P=3, two toggles
      cfg_wr(0, 3, 2);
      for (int i = 0; i <= 8; i++) begin
         start[0] = (i == 0);
         tick();
         check("t2_tgl",  32'(tgl_en[0]), 32'(i == 3 || i == 6));
         check("t2_done", 32'(done[0]),   32'(i == 6));
         check("t2_busy", 32'(busy[0]),   32'(i < 7));
         check("t2_q",    32'(q[0]),      32'(i >= 4 && i < 7));
      end
      start = '0;

      // ch1 P=0 free-run, then stop
      cfg_wr(1, 0, 0);
      for (int i = 0; i <= 8; i++) begin
         start[1] = (i == 0);
         tick();
         check("t3_tgl", 32'(tgl_en[1]), 32'(i >= 1));
         check("t3_q",   32'(q[1]),      32'((i >= 2) ? ((i - 1) & 1) : 0));
      end
      start = '0;
      stop[1] = 1'b1; tick(); stop = '0;
      check("t3_stop_tgl", 32'(tgl_en[1]), 32'(0));
      repeat (3) begin
         tick();
         check("t3_hold_q", 32'(q[1]), 32'(0));
      end

      // config blocked on busy ch2, accepted on idle ch3
      cfg_wr(2, 20, 0);
      start[2] = 1'b1; tick(); start = '0;
      repeat (3) tick();
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd5; cfg_count = 8'd0;
      #1 check("t4_rdy_busy", 32'(cfg_ready), 32'(0));
      tick();
      cfg_ch = 2'd3; cfg_period = 8'd2; cfg_count = 8'd3;
      #1 check("t4_rdy_idle", 32'(cfg_ready), 32'(1));
      tick();
      cfg_valid = 1'b0;
      stop[2] = 1'b1; tick(); stop = '0;
      start[2] = 1'b1; tick(); start = '0;
      pulses = 0;
      repeat (25) begin
         tick();
         pulses += int'(tgl_en[2]);
      end
      check("t4_cfg_kept", 32'(pulses), 32'(1));
      stop_all();

      // start+stop on idle ch0, then restart attempt mid-period
      start[0] = 1'b1; stop[0] = 1'b1; tick(); start = '0; stop = '0;
      check("t5_ss_busy", 32'(busy[0]), 32'(0));
      tick();
      check("t5_ss_busy2", 32'(busy[0]), 32'(0));
      cfg_wr(0, 4, 0);
      for (int i = 0; i <= 12; i++) begin
         start[0] = (i == 0 || i == 6);
         tick();
         check("t5_spacing", 32'(tgl_en[0]), 32'(i > 0 && i % 4 == 0));
      end
      start = '0;
      stop_all();

      // all channels P=1, count=4 together
      for (int c = 0; c < NUM_CH; c++) cfg_wr(c, 1, 4);
      for (int i = 0; i <= 5; i++) begin
         start = (i == 0) ? '1 : '0;
         tick();
         check("t6_tgl",  32'(tgl_en), 32'((i >= 1 && i <= 4) ? 4'hf : 4'h0));
         check("t6_done", 32'(done),   32'((i == 4) ? 4'hf : 4'h0));
         check("t6_busy", 32'(busy),   32'((i < 5) ? 4'hf : 4'h0));
      end
      start = '0;

      // reset during RUN, then fresh start
      cfg_wr(0, 3, 0);
      start[0] = 1'b1; cfg_wr(1, 0, 0); start = '0;
      start[1] = 1'b1; tick(); start = '0;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      check("t1_busy", 32'(busy),   32'(0));
      check("t1_tgl",  32'(tgl_en), 32'(0));
      check("t1_done", 32'(done),   32'(0));
      check("t1_q",    32'(q),      32'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         start[0] = (i == 0);
         tick();
         check("t1_fresh_tgl", 32'(tgl_en[0]), 32'(i >= 1));
      end
      start = '0;
      stop_all();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cfg_valid  = 1'($urandom_range(0, 1));
         cfg_ch     = 2'($urandom_range(0, 3));
         cfg_period = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 40))
                                                   : CNT_W'($urandom_range(0, 5));
         cfg_count  = CNT_W'($urandom_range(0, 5));
         start      = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         stop       = 4'($urandom_range(0, 15) & $urandom_range(0, 15) &
                         $urandom_range(0, 15) & $urandom_range(0, 15));
         tick();
      end
      idle_inputs();
      stop_all();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
